// File: rtl/sync_bits_pkg.sv
// Shared helpers for sync_bits_filter: filter counter width and parameter legality.
package sync_bits_pkg;

    // Counter holds 0..FILT_CNT-1; always at least one bit wide.
    function automatic int cnt_w(input int filtCnt);
        return (filtCnt <= 2) ? 1 : $clog2(filtCnt);
    endfunction

    function automatic bit params_ok(input int width, input int depth, input int filtCnt);
        return (width >= 1) && (depth >= 2) && (filtCnt >= 1);
    endfunction

endpackage

// File: rtl/sync_bits_filter_lane.sv
// One lane of sync_bits_filter: DEPTH-flop synchroniser, stability counter,
// filtered level and registered rise/fall pulses.
module sync_bits_filter_lane
    import sync_bits_pkg::*;
#(
    parameter int   DEPTH    = 2,
    parameter int   FILT_CNT = 4,
    parameter logic INIT     = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic dIn,
    output logic dOut,
    output logic rise,
    output logic fall,
    output logic pulseNxt
);
    localparam int            CW       = cnt_w(FILT_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

    logic [DEPTH-1:0] syncQ;
    logic [CW-1:0]    cnt, cntNxt;
    logic             y, accept;

    assign y        = syncQ[DEPTH-1];
    assign pulseNxt = accept;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) syncQ <= {DEPTH{INIT}};
        else     syncQ <= {syncQ[DEPTH-2:0], dIn};
    end

    // Any return of y to the accepted level discards the partial count.
    always_comb begin
        accept = 1'b0;
        cntNxt = cnt;
        if (y == dOut) begin
            cntNxt = '0;
        end else if (EN) begin
            if (cnt == CNT_LAST) begin
                accept = 1'b1;
                cntNxt = '0;
            end else begin
                cntNxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt  <= '0;
            dOut <= INIT;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            cnt  <= cntNxt;
            rise <= accept & y;
            fall <= accept & ~y;
            if (accept) dOut <= y;
        end
    end

endmodule

// File: rtl/sync_bits_filter.sv
// Multi-bit synchroniser with per-lane glitch filter and edge pulses.
// Define SYNC_BITS_FILTER_STICKY_EN to add the STICKY_CLR/STICKY change-capture register.
module sync_bits_filter
    import sync_bits_pkg::*;
#(
    parameter int               WIDTH    = 1,
    parameter int               DEPTH    = 2,
    parameter int               FILT_CNT = 4,
    parameter logic [WIDTH-1:0] INIT     = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] D_IN,
`ifdef SYNC_BITS_FILTER_STICKY_EN
    input  logic             STICKY_CLR,
    output logic [WIDTH-1:0] STICKY,
`endif
    output logic [WIDTH-1:0] D_OUT,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic             CHG
);
    logic [WIDTH-1:0] pulseNxt;

    generate
        if (!params_ok(WIDTH, DEPTH, FILT_CNT)) begin : gBadParams
            $error("sync_bits_filter: illegal WIDTH/DEPTH/FILT_CNT");
        end
        for (genvar i = 0; i < WIDTH; i++) begin : gLane
            sync_bits_filter_lane #(
                .DEPTH    (DEPTH),
                .FILT_CNT (FILT_CNT),
                .INIT     (INIT[i])
            ) uLane (
                .CLK      (CLK),
                .RST      (RST),
                .EN       (EN),
                .dIn      (D_IN[i]),
                .dOut     (D_OUT[i]),
                .rise     (RISE[i]),
                .fall     (FALL[i]),
                .pulseNxt (pulseNxt[i])
            );
        end
    endgenerate

    // Registered from the lanes' next-pulse terms so CHG lines up with RISE/FALL.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) CHG <= 1'b0;
        else     CHG <= |pulseNxt;
    end

`ifdef SYNC_BITS_FILTER_STICKY_EN
    // A pulse in the same cycle as the clear survives it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)             STICKY <= '0;
        else if (STICKY_CLR) STICKY <= RISE | FALL;
        else                 STICKY <= STICKY | RISE | FALL;
    end
`endif

endmodule

// File: tb/tb_sync_bits_filter.sv
// Scoreboard bench for sync_bits_filter: a 4-lane DEPTH=2/FILT_CNT=4 instance
// and a 1-lane DEPTH=3/FILT_CNT=1 instance, each compared every cycle against a model.
module tb_sync_bits_filter;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN  = 1'b1;
    logic [3:0] dIn = 4'hF;
    logic [3:0] dOut, rise, fall, sticky;
    logic       chg;
    logic       bIn = 1'b0;
    logic       bOut, bRise, bFall, bChg;
    logic       stkClr = 1'b0;

    always #5 CLK = ~CLK;

    sync_bits_filter #(.WIDTH(4), .DEPTH(2), .FILT_CNT(4), .INIT(4'h0)) dutA (
        .CLK(CLK), .RST(RST), .EN(EN), .D_IN(dIn),
`ifdef SYNC_BITS_FILTER_STICKY_EN
        .STICKY_CLR(stkClr), .STICKY(sticky),
`endif
        .D_OUT(dOut), .RISE(rise), .FALL(fall), .CHG(chg)
    );

`ifdef SYNC_BITS_FILTER_STICKY_EN
    logic bSticky;
`else
    assign sticky = 4'h0;
`endif

    sync_bits_filter #(.WIDTH(1), .DEPTH(3), .FILT_CNT(1), .INIT(1'b0)) dutB (
        .CLK(CLK), .RST(RST), .EN(1'b1), .D_IN(bIn),
`ifdef SYNC_BITS_FILTER_STICKY_EN
        .STICKY_CLR(1'b0), .STICKY(bSticky),
`endif
        .D_OUT(bOut), .RISE(bRise), .FALL(bFall), .CHG(bChg)
    );

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    logic [20:0] sbq[$];

    // Reference state for dutA (cycle model) and dutB (pure delay line).
    logic [3:0] mS0, mS1, mOut, mRise, mFall, mSticky, mHist;
    logic       mChg, mBOut, mBRise, mBFall;
    int         mCnt[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mdlReset();
        mS0 = 4'h0; mS1 = 4'h0; mOut = 4'h0; mRise = 4'h0; mFall = 4'h0;
        mSticky = 4'h0; mHist = 4'h0; mChg = 1'b0;
        mBOut = 1'b0; mBRise = 1'b0; mBFall = 1'b0;
        foreach (mCnt[i]) mCnt[i] = 0;
    endtask

    task automatic mdlStep();
        logic [3:0] y, nR, nF;
        if (RST) begin
            mdlReset();
        end else begin
            y = mS1; nR = 4'h0; nF = 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (y[i] == mOut[i]) mCnt[i] = 0;
                else if (EN) begin
                    if (mCnt[i] == 3) begin
                        mCnt[i] = 0; nR[i] = y[i]; nF[i] = ~y[i];
                    end else mCnt[i]++;
                end
            end
`ifdef SYNC_BITS_FILTER_STICKY_EN
            mSticky = (stkClr ? 4'h0 : mSticky) | mRise | mFall;
`endif
            mOut  = mOut ^ (nR | nF);
            mRise = nR; mFall = nF; mChg = |(nR | nF);
            mS1 = mS0; mS0 = dIn;
            // dutB: level after this edge equals the input captured three edges earlier
            mHist  = {mHist[2:0], bIn};
            mBRise = mHist[3] & ~mBOut;
            mBFall = ~mHist[3] & mBOut;
            mBOut  = mHist[3];
        end
    endtask

    task automatic tick();
        logic [20:0] g, e;
        @(posedge CLK);
        mdlStep();
        sbq.push_back({mOut, mRise, mFall, mChg, mSticky, mBOut, mBRise, mBFall, mBRise | mBFall});
        #1;
        cyc++;
        bIn = cyc[2];
        g = {dOut, rise, fall, chg, sticky, bOut, bRise, bFall, bChg};
        e = sbq.pop_front();
        chk("sb", g, e);
    endtask

    initial begin
        mdlReset();
        repeat (3) tick();
        chk("rst_dout", dOut, 4'h0);
        chk("rst_pulse", {rise, fall, chg}, 9'h0);

        // release with D_IN != INIT: no pulse from reset, acceptance at edge 6
        RST = 1'b0;
        repeat (5) tick();
        chk("rel_pre", dOut, 4'h0);
        tick();
        chk("rel_dout", dOut, 4'hF);
        chk("rel_rise", rise, 4'hF);
        chk("rel_chg", chg, 1'b1);
        tick();
        chk("rel_rise_1cyc", {rise, chg}, 5'h0);

        dIn = 4'h0;
        repeat (8) tick();
        chk("fall_all", dOut, 4'h0);

        // 3-cycle glitch rejected, 4-cycle pulse accepted
        dIn[0] = 1'b1; repeat (3) tick();
        dIn[0] = 1'b0; repeat (8) tick();
        chk("glitch3", dOut[0], 1'b0);
        dIn[0] = 1'b1; repeat (4) tick();
        dIn[0] = 1'b0; tick();
        chk("pulse4_pre", dOut[0], 1'b0);
        tick();
        chk("pulse4_acc", {dOut[0], rise[0]}, 2'b11);
        repeat (8) tick();

        // EN alternating: four enabled mismatch edges land on edge 9
        dIn[1] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            EN = (k % 2) == 1;
            tick();
            if (k == 8) chk("en_hold", dOut[1], 1'b0);
            if (k == 9) chk("en_acc", {dOut[1], rise[1]}, 2'b11);
        end
        EN = 1'b1;

        // async reset while counters are mid-way
        dIn = 4'hF;
        repeat (8) tick();
        chk("pre_async", dOut, 4'hF);
        dIn = 4'h0;
        repeat (4) tick();
        #3 RST = 1'b1;
        mdlReset();
        #1 chk("async_rst", {dOut, rise, fall, chg}, 13'h0);
        tick();
        dIn = 4'h5;
        RST = 1'b0;
        repeat (5) tick();
        chk("fresh_pre", dOut, 4'h0);
        tick();
        chk("fresh_acc", dOut, 4'h5);
        repeat (2) tick();

`ifdef SYNC_BITS_FILTER_STICKY_EN
        dIn = 4'h1;
        repeat (6) tick();
        chk("fall2", fall, 4'h4);
        stkClr = 1'b1; tick(); stkClr = 1'b0;
        chk("sticky_set_wins", sticky, 4'h4);
        stkClr = 1'b1; tick(); stkClr = 1'b0;
        chk("sticky_clr", sticky, 4'h0);
`endif

        repeat (12) tick();
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
